// File: rtl/bv8_basis_pipe.sv
// bv8_basis_pipe: AES forward/backward basis change on every share of every byte lane, behind a 2-entry elastic buffer.
// Latency: 1 cycle from an accepted input to out_valid (empty buffer, or one entry popping in the same cycle).
// Backpressure: in_ready = (count != 2) comes from registered state only; out_y/out_mode stay stable while stalled.
//
// Ports:
//   in_clock, in_reset_n       clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          upstream handshake; in_mode and in_x are sampled on push
//   in_x                       8*LANES*SHARES bits, byte (s*LANES+l) = share s of lane l
//   in_random                  only with BV8_BASIS_REFRESH_EN: 8*LANES*(SHARES-1) bits of fresh mask, sampled on push
//   out_valid/out_ready        downstream handshake
//   out_y, out_mode            head entry: transformed shares (same packing as in_x) and its mode
//
// Optional feature macro: BV8_BASIS_REFRESH_EN (share remasking; requires SHARES >= 2).
module bv8_basis_pipe #(
  parameter int LANES  = 4,
  parameter int SHARES = 2
) (
  input  logic                         in_clock,
  input  logic                         in_reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [8*LANES*SHARES-1:0]    in_x,
`ifdef BV8_BASIS_REFRESH_EN
  input  logic [8*LANES*(SHARES-1)-1:0] in_random,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8*LANES*SHARES-1:0]    out_y,
  output logic                         out_mode
);

  localparam int W = 8 * LANES * SHARES;

`ifdef BV8_BASIS_REFRESH_EN
  if (SHARES < 2) begin : g_bad_shares
    $error("bv8_basis_pipe: BV8_BASIS_REFRESH_EN requires SHARES >= 2");
  end
`endif

  // Forward basis change for one byte (x[0] is the LSB).
  function automatic logic [7:0] fwd_map(input logic [7:0] x);
    logic [7:0] y;
    y[0] = x[1] ^ x[4] ^ x[6];
    y[1] = x[1] ^ x[4] ^ x[5];
    y[2] = x[0] ^ x[2] ^ x[3] ^ x[5] ^ x[6];
    y[3] = x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    y[4] = x[3] ^ x[5] ^ x[7];
    y[5] = x[0] ^ x[6];
    y[6] = x[3] ^ x[7];
    y[7] = x[3] ^ x[5];
    return y;
  endfunction

  // Backward basis change for one byte.
  function automatic logic [7:0] bwd_map(input logic [7:0] x);
    logic [7:0] y;
    y[0] = x[2];
    y[1] = x[1] ^ x[5];
    y[2] = x[1] ^ x[4] ^ x[5] ^ x[7];
    y[3] = x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5] ^ x[6];
    y[4] = x[1] ^ x[6];
    y[5] = x[0] ^ x[2] ^ x[3] ^ x[5] ^ x[6] ^ x[7];
    y[6] = x[0] ^ x[1] ^ x[3] ^ x[5] ^ x[6] ^ x[7];
    y[7] = x[1] ^ x[4];
    return y;
  endfunction

  logic [W-1:0] xform;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         head_mode_q, head_mode_d;
  logic         tail_mode_q, tail_mode_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  // The map is linear, so it is applied to each share on its own; shares are never mixed.
  always_comb begin
    xform = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        xform[8*(s*LANES+l) +: 8] = in_mode ? bwd_map(in_x[8*(s*LANES+l) +: 8])
                                            : fwd_map(in_x[8*(s*LANES+l) +: 8]);
      end
    end
`ifdef BV8_BASIS_REFRESH_EN
    // Each random byte lands on share s and on share 0 of the same lane, so the
    // XOR over all shares (the unmasked value) is unchanged.
    for (int l = 0; l < LANES; l++) begin
      for (int s = 1; s < SHARES; s++) begin
        xform[8*(s*LANES+l) +: 8] = xform[8*(s*LANES+l) +: 8] ^ in_random[8*((s-1)*LANES+l) +: 8];
        xform[8*l +: 8]           = xform[8*l +: 8] ^ in_random[8*((s-1)*LANES+l) +: 8];
      end
    end
`endif
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_y     = head_q;
  assign out_mode  = head_mode_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Popped entries are left in place (not cleared); only reset wipes share data.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    head_mode_d = head_mode_q;
    tail_mode_d = tail_mode_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d      = xform;
          head_mode_d = in_mode;
        end else begin
          tail_d      = xform;
          tail_mode_d = in_mode;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d      = tail_q;
          head_mode_d = tail_mode_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1: there is no tail, the new entry becomes head.
        head_d      = xform;
        head_mode_d = in_mode;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_mode_q <= 1'b0;
      tail_mode_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_mode_q <= head_mode_d;
      tail_mode_q <= tail_mode_d;
      count_q     <= count_d;
    end
  end

endmodule
